// File: rtl/rx_lbuf_ring_ctrl_pkg.sv
// rtl/rx_lbuf_ring_ctrl_pkg.sv - shared types and helpers for the RX lbuf ring controller
package rx_lbuf_ring_ctrl_pkg;

    localparam int DEF_RING_LOG2 = 16;
    localparam int DEF_LBUF_LOG2 = 12;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_READY   = 4'b0010,
        ST_STALL   = 4'b0100,
        ST_GRANTED = 4'b1000
    } lbuf_state_t;

    function automatic int idx_width(input int ring_log2, input int lbuf_log2);
        return ring_log2 - lbuf_log2;
    endfunction

    // Host byte address of lbuf number idx within the ring at base.
    function automatic logic [63:0] lbuf_addr_of(input logic [63:0] base,
                                                 input logic [63:0] idx,
                                                 input int          lbuf_log2);
        return base + (idx << lbuf_log2);
    endfunction

endpackage

// File: rtl/rx_lbuf_ring_ctrl_if.sv
// rtl/rx_lbuf_ring_ctrl_if.sv - lbuf request/grant handshake between RX DMA and ring controller
interface rx_lbuf_ring_ctrl_if;
    logic        lbuf_req;
    logic        lbuf_gnt;
    logic [63:0] lbuf_addr;
    logic        lbuf_done;

    modport master (
        output lbuf_req,
        output lbuf_done,
        input  lbuf_gnt,
        input  lbuf_addr
    );

    modport slave (
        input  lbuf_req,
        input  lbuf_done,
        output lbuf_gnt,
        output lbuf_addr
    );
endinterface

// File: rtl/rx_lbuf_swptr_dec.sv
// rtl/rx_lbuf_swptr_dec.sv - sw_ptr change detect, range/alignment check and index extraction
module rx_lbuf_swptr_dec
    import rx_lbuf_ring_ctrl_pkg::*;
#(
    parameter int RING_LOG2 = DEF_RING_LOG2,
    parameter int LBUF_LOG2 = DEF_LBUF_LOG2,
    parameter int IDX_W     = idx_width(RING_LOG2, LBUF_LOG2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ring_en,
    input  logic [63:0]      host_base,
    input  logic [63:0]      sw_ptr,
    output logic             sw_idx_wr,
    output logic [IDX_W-1:0] sw_idx_new,
    output logic             sw_bad
);

    logic [63:0] sw_prev;
    logic [63:0] off;
    logic        changed;
    logic        in_range;
    logic        aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_prev <= '0;
        end else begin
            sw_prev <= sw_ptr;
        end
    end

    // Only a new value is a write-back; a repeated pointer carries no information.
    assign changed    = ring_en && (sw_ptr != sw_prev);
    assign off        = sw_ptr - host_base;
    assign in_range   = (off >> RING_LOG2) == 64'd0;
    assign aligned    = off[LBUF_LOG2-1:0] == '0;

    assign sw_idx_wr  = changed && in_range && aligned;
    assign sw_bad     = changed && !(in_range && aligned);
    assign sw_idx_new = off[RING_LOG2-1:LBUF_LOG2];

endmodule

// File: rtl/rx_lbuf_ring_ctrl.sv
// rtl/rx_lbuf_ring_ctrl.sv - RX lbuf ring controller; RX_STALL_CNT_EN builds the stall-cycle counter
module rx_lbuf_ring_ctrl
    import rx_lbuf_ring_ctrl_pkg::*;
#(
    parameter  int RING_LOG2 = DEF_RING_LOG2,
    parameter  int LBUF_LOG2 = DEF_LBUF_LOG2,
    localparam int IDX_W     = idx_width(RING_LOG2, LBUF_LOG2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ring_en,
    input  logic [63:0]            host_base,
    input  logic [63:0]            sw_ptr,
    rx_lbuf_ring_ctrl_if.slave     lbuf,
    output logic [IDX_W-1:0]       free_lbufs,
    output logic                   ring_full,
    output logic                   sw_err,
    output logic [31:0]            stall_cnt
);

    lbuf_state_t      state, state_nxt;
    logic [IDX_W-1:0] hw_idx, hw_nxt;
    logic [IDX_W-1:0] sw_idx, sw_nxt;
    logic [IDX_W-1:0] free_q, free_nxt;
    logic [IDX_W-1:0] used_nxt;
    logic             err_q, err_nxt;
    logic             gnt_q, gnt_nxt;
    logic [63:0]      addr_q, addr_nxt;

    logic             sw_idx_wr;
    logic [IDX_W-1:0] sw_idx_new;
    logic             sw_bad;

    rx_lbuf_swptr_dec #(
        .RING_LOG2 (RING_LOG2),
        .LBUF_LOG2 (LBUF_LOG2),
        .IDX_W     (IDX_W)
    ) u_swptr_dec (
        .clk        (clk),
        .rst_n      (rst_n),
        .ring_en    (ring_en),
        .host_base  (host_base),
        .sw_ptr     (sw_ptr),
        .sw_idx_wr  (sw_idx_wr),
        .sw_idx_new (sw_idx_new),
        .sw_bad     (sw_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            hw_idx <= '0;
            sw_idx <= '0;
            free_q <= '0;
            err_q  <= 1'b0;
            gnt_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            hw_idx <= hw_nxt;
            sw_idx <= sw_nxt;
            free_q <= free_nxt;
            err_q  <= err_nxt;
            gnt_q  <= gnt_nxt;
            addr_q <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hw_nxt    = hw_idx;
        sw_nxt    = sw_idx;
        err_nxt   = err_q;
        gnt_nxt   = 1'b0;
        addr_nxt  = addr_q;

        if (sw_idx_wr) begin
            sw_nxt = sw_idx_new;
        end
        if (sw_bad) begin
            err_nxt = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (ring_en) begin
                    state_nxt = ST_READY;
                    hw_nxt    = '0;
                    sw_nxt    = '0;
                    err_nxt   = 1'b0;
                end
            end
            ST_READY: begin
                if (!ring_en) begin
                    state_nxt = ST_IDLE;
                end else if (lbuf.lbuf_req) begin
                    if (free_q != '0) begin
                        gnt_nxt   = 1'b1;
                        addr_nxt  = lbuf_addr_of(host_base, 64'(hw_idx), LBUF_LOG2);
                        state_nxt = ST_GRANTED;
                    end else begin
                        state_nxt = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!ring_en) begin
                    state_nxt = ST_IDLE;
                end else if (free_q != '0) begin
                    state_nxt = ST_READY;
                end
            end
            ST_GRANTED: begin
                // A grant in flight is always completed, even if the ring is being disabled.
                if (lbuf.lbuf_done) begin
                    hw_nxt    = hw_idx + IDX_W'(1);
                    state_nxt = ring_en ? ST_READY : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Occupancy is taken from the indices being written this edge, so a READY
    // cycle that follows lbuf_done or a sw_ptr update never sees a stale count.
    assign used_nxt = hw_nxt - sw_nxt;
    assign free_nxt = (state_nxt == ST_IDLE) ? '0 : ({IDX_W{1'b1}} - used_nxt);

    assign lbuf.lbuf_gnt  = gnt_q;
    assign lbuf.lbuf_addr = addr_q;
    assign free_lbufs     = free_q;
    assign sw_err         = err_q;
    assign ring_full      = (state == ST_STALL) || ((state != ST_IDLE) && (free_q == '0));

`ifdef RX_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state == ST_IDLE) && (state_nxt == ST_READY)) begin
            stall_q <= '0;
        end else if ((state == ST_STALL) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
